// File: rtl/noc_output_scheduler_if.sv
// Handshake bundle between the requesters/downstream (master) and the output scheduler (slave).
// ARB_GRANT_COUNT_EN adds the per-requester grant-count bus.
interface noc_output_scheduler_if #(
  parameter int WIDTH = 11,
  parameter int NREQ  = 5,
  parameter int ID_W  = 3
`ifdef ARB_GRANT_COUNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic [NREQ-1:0]       in_valid;
  logic [NREQ*WIDTH-1:0] in_data;
  logic [NREQ-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [ID_W-1:0]       out_src;
  logic                  out_ready;
  logic [ID_W-1:0]       rr_ptr;
`ifdef ARB_GRANT_COUNT_EN
  logic [NREQ*CNT_W-1:0] grant_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src, rr_ptr, grant_cnt
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src, rr_ptr, grant_cnt
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src, rr_ptr
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src, rr_ptr
  );
`endif
endinterface

// File: rtl/noc_output_scheduler.sv
// Round-robin scheduler for one router output port with a single registered output stage.
// Define ARB_GRANT_COUNT_EN to add saturating per-requester grant counters.
module noc_output_scheduler #(
  parameter int WIDTH = 11,
  parameter int NREQ  = 5,
  parameter int ID_W  = 3
`ifdef ARB_GRANT_COUNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  noc_output_scheduler_if.slave  bus
);

  logic [WIDTH-1:0] pkt [NREQ];
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]  out_src_q, out_src_d;
  logic [ID_W-1:0]  sel;
  logic             any_valid;
  logic             load;
  logic             grant;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pkt
      assign pkt[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Scan from the highest rotated offset down so the last hit is the first in pointer order.
  always_comb begin
    int idx;
    idx       = 0;
    sel       = '0;
    any_valid = 1'b0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.in_valid[idx]) begin
        any_valid = 1'b1;
        sel       = ID_W'(idx);
      end
    end
  end

  assign load  = ~out_valid_q | bus.out_ready;
  assign grant = load & any_valid;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign bus.in_ready[gi] = rst_n & grant & (sel == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q & ~bus.out_ready;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = pkt[sel];
      out_src_d   = sel;
      ptr_d       = (sel == ID_W'(NREQ-1)) ? '0 : sel + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.rr_ptr    = ptr_q;

`ifdef ARB_GRANT_COUNT_EN
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (grant && (sel == ID_W'(gi)) && (cnt_q != {CNT_W{1'b1}}))
          cnt_d = cnt_q + CNT_W'(1);
      end

      always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end

      assign bus.grant_cnt[gi*CNT_W +: CNT_W] = cnt_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_noc_output_scheduler.sv
// Self-checking bench for noc_output_scheduler: directed scenarios plus random traffic against a queue-free reference model.
module tb_noc_output_scheduler;
  localparam int WIDTH = 11;
  localparam int NREQ  = 5;
  localparam int ID_W  = 3;
`ifdef ARB_GRANT_COUNT_EN
  localparam int CNT_W = 4;
`endif

  logic clk;
  logic rst_n;

`ifdef ARB_GRANT_COUNT_EN
  noc_output_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();
  noc_output_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
`else
  noc_output_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ), .ID_W(ID_W)) bus ();
  noc_output_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Requester / downstream stimulus
  logic [NREQ-1:0]  vld;
  logic [WIDTH-1:0] dat [NREQ];
  logic             ordy;

  // Reference model state
  int               m_ptr;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_src;
  logic             m_load, m_any;
  int               m_sel;
  logic [NREQ-1:0]  m_ready;
  logic [NREQ-1:0]  m_acc;
  int               m_cnt [NREQ];

  task automatic apply();
    bus.in_valid  = vld;
    for (int i = 0; i < NREQ; i++) bus.in_data[i*WIDTH +: WIDTH] = dat[i];
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic model_eval();
    m_load  = !m_valid || ordy;
    m_any   = 1'b0;
    m_sel   = 0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (!m_any && vld[idx]) begin
        m_any = 1'b1;
        m_sel = idx;
      end
    end
    m_ready = '0;
    if (rst_n && m_load && m_any) m_ready[m_sel] = 1'b1;
  endtask

  task automatic tick();
    model_eval();
    m_acc = m_ready;
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    end else if (m_load && m_any) begin
      m_valid = 1'b1;
      m_data  = dat[m_sel];
      m_src   = m_sel;
      m_ptr   = (m_sel + 1) % NREQ;
      if (m_cnt[m_sel] < 15) m_cnt[m_sel] = m_cnt[m_sel] + 1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vld   = '0;
    ordy  = 1'b0;
    for (int i = 0; i < NREQ; i++) dat[i] = '0;
    apply();
    tick();
    tick();
    rst_n = 1'b1;
    apply();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vld   = '1;
    ordy  = 1'b1;
    for (int i = 0; i < NREQ; i++) dat[i] = WIDTH'(11'h100 + i);
    apply();
    n_total++; if (bus.in_ready !== 5'b00000) $display("FAIL reset_in_ready got %b want 00000", bus.in_ready); else n_pass++;
    tick();
    tick();
    n_total++; if (bus.in_ready !== 5'b00000) $display("FAIL reset_in_ready_held got %b want 00000", bus.in_ready); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.rr_ptr !== 3'd0) $display("FAIL reset_rr_ptr got %0d want 0", bus.rr_ptr); else n_pass++;
    n_total++; if (bus.out_data !== 11'h000 || bus.out_src !== 3'd0)
      $display("FAIL reset_out_data_src got %h/%0d want 000/0", bus.out_data, bus.out_src); else n_pass++;
    rst_n = 1'b1;
    apply();
    n_total++; if (bus.in_ready !== 5'b00001) $display("FAIL reset_first_ready got %b want 00001", bus.in_ready); else n_pass++;
    tick();
    n_total++; if (bus.out_valid !== 1'b1 || bus.out_src !== 3'd0 || bus.out_data !== 11'h100)
      $display("FAIL reset_first_grant got v%b src%0d %h want v1 src0 100", bus.out_valid, bus.out_src, bus.out_data); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_round_robin();
    do_reset();
    vld  = '1;
    ordy = 1'b1;
    for (int i = 0; i < NREQ; i++) dat[i] = WIDTH'(11'h100 + i);
    for (int c = 0; c < 10; c++) begin
      logic [NREQ-1:0]  exp_rdy;
      logic [ID_W-1:0]  exp_src;
      logic [WIDTH-1:0] exp_dat;
      exp_rdy = '0;
      exp_rdy[c % NREQ] = 1'b1;
      exp_src = ID_W'(c % NREQ);
      exp_dat = WIDTH'(11'h100 + (c % NREQ));
      apply();
      n_total++; if (bus.in_ready !== exp_rdy) $display("FAIL rr_ready c%0d got %b want %b", c, bus.in_ready, exp_rdy); else n_pass++;
      tick();
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_src !== exp_src || bus.out_data !== exp_dat)
        $display("FAIL rr_out c%0d got v%b src%0d %h want v1 src%0d %h", c, bus.out_valid, bus.out_src, bus.out_data, exp_src, exp_dat);
      else n_pass++;
      $display("rr grant %0d src=%0d data=%h", c, bus.out_src, bus.out_data);
    end
  endtask

  task automatic test_lone();
    do_reset();
    vld    = 5'b00100;
    dat[2] = 11'h222;
    ordy   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      apply();
      tick();
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_src !== 3'd2 || bus.rr_ptr !== 3'd3)
        $display("FAIL lone c%0d got v%b src%0d ptr%0d want v1 src2 ptr3", c, bus.out_valid, bus.out_src, bus.rr_ptr);
      else n_pass++;
    end
    vld    = 5'b01110;
    dat[1] = 11'h111;
    dat[3] = 11'h333;
    apply();
    tick();
    n_total++; if (bus.out_src !== 3'd3 || bus.out_data !== 11'h333)
      $display("FAIL lone_raise_first got src%0d %h want src3 333", bus.out_src, bus.out_data); else n_pass++;
    apply();
    tick();
    n_total++; if (bus.out_src !== 3'd1 || bus.out_data !== 11'h111)
      $display("FAIL lone_raise_second got src%0d %h want src1 111", bus.out_src, bus.out_data); else n_pass++;
    $display("test_lone done");
  endtask

  task automatic test_backpressure();
    do_reset();
    vld    = 5'b00001;
    dat[0] = 11'h2AB;
    ordy   = 1'b1;
    apply();
    tick();
    dat[0] = 11'h155;
    ordy   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      apply();
      n_total++; if (bus.in_ready !== 5'b00000) $display("FAIL bp_ready c%0d got %b want 00000", c, bus.in_ready); else n_pass++;
      tick();
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 11'h2AB || bus.out_src !== 3'd0)
        $display("FAIL bp_hold c%0d got v%b %h src%0d want v1 2ab src0", c, bus.out_valid, bus.out_data, bus.out_src);
      else n_pass++;
    end
    ordy = 1'b1;
    apply();
    n_total++; if (bus.in_ready !== 5'b00001) $display("FAIL bp_release_ready got %b want 00001", bus.in_ready); else n_pass++;
    tick();
    n_total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 11'h155)
      $display("FAIL bp_release got v%b %h want v1 155", bus.out_valid, bus.out_data); else n_pass++;
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    vld    = 5'b00010;
    dat[1] = 11'h0AA;
    ordy   = 1'b1;
    apply();
    tick();
    ordy = 1'b0;
    apply();
    tick();
    n_total++; if (bus.out_valid !== 1'b1 || bus.rr_ptr !== 3'd2)
      $display("FAIL stall_setup got v%b ptr%0d want v1 ptr2", bus.out_valid, bus.rr_ptr); else n_pass++;
    rst_n = 1'b0;
    apply();
    n_total++; if (bus.in_ready !== 5'b00000) $display("FAIL stall_rst_ready got %b want 00000", bus.in_ready); else n_pass++;
    tick();
    n_total++; if (bus.out_valid !== 1'b0 || bus.rr_ptr !== 3'd0)
      $display("FAIL stall_rst got v%b ptr%0d want v0 ptr0", bus.out_valid, bus.rr_ptr); else n_pass++;
    rst_n = 1'b1;
    vld   = '0;
    ordy  = 1'b1;
    apply();
    tick();
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL stall_lost got v%b want v0", bus.out_valid); else n_pass++;
    $display("test_reset_mid_stall done");
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      vld[i] = 1'($urandom_range(0, 1));
      dat[i] = WIDTH'($urandom);
    end
    for (int c = 0; c < 400; c++) begin
      ordy = ($urandom_range(0, 3) != 0);
      apply();
      model_eval();
      n_total++;
      if (bus.in_ready !== m_ready) begin
        errs++;
        $display("FAIL rand_ready c%0d got %b want %b", c, bus.in_ready, m_ready);
      end else n_pass++;
      tick();
      n_total++;
      if (bus.out_valid !== m_valid || bus.out_data !== m_data ||
          bus.out_src !== ID_W'(m_src) || bus.rr_ptr !== ID_W'(m_ptr)) begin
        errs++;
        $display("FAIL rand_out c%0d got v%b %h src%0d ptr%0d want v%b %h src%0d ptr%0d", c,
                 bus.out_valid, bus.out_data, bus.out_src, bus.rr_ptr, m_valid, m_data, m_src, m_ptr);
      end else n_pass++;
      for (int i = 0; i < NREQ; i++) begin
        if (m_acc[i] || !vld[i]) begin
          vld[i] = 1'($urandom_range(0, 1));
          dat[i] = WIDTH'($urandom);
        end
      end
    end
`ifdef ARB_GRANT_COUNT_EN
    for (int i = 0; i < NREQ; i++) begin
      n_total++;
      if (bus.grant_cnt[i*CNT_W +: CNT_W] !== CNT_W'(m_cnt[i])) begin
        errs++;
        $display("FAIL rand_cnt%0d got %0d want %0d", i, bus.grant_cnt[i*CNT_W +: CNT_W], m_cnt[i]);
      end else n_pass++;
    end
`endif
    $display("test_random done, %0d errors", errs);
  endtask

`ifdef ARB_GRANT_COUNT_EN
  task automatic test_grant_count();
    do_reset();
    vld    = 5'b10000;
    dat[4] = 11'h044;
    ordy   = 1'b1;
    for (int c = 0; c < 20; c++) begin
      apply();
      tick();
    end
    for (int i = 0; i < NREQ; i++) begin
      logic [CNT_W-1:0] exp_cnt;
      exp_cnt = (i == 4) ? 4'd15 : 4'd0;
      n_total++; if (bus.grant_cnt[i*CNT_W +: CNT_W] !== exp_cnt)
        $display("FAIL cnt_sat%0d got %0d want %0d", i, bus.grant_cnt[i*CNT_W +: CNT_W], exp_cnt);
      else n_pass++;
    end
    $display("test_grant_count done");
  endtask
`endif

  initial begin
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_src = 0;
    m_acc = '0; m_ready = '0; m_load = 1'b0; m_any = 1'b0; m_sel = 0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    test_reset();
    test_round_robin();
    test_lone();
    test_backpressure();
    test_reset_mid_stall();
    test_random();
`ifdef ARB_GRANT_COUNT_EN
    test_grant_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
